ahb_slave_ws: RTL and testbench

Parametrised AHB-Lite memory slave; successor to the fixed zero-wait ahb_slave.
- Adds configurable data/address width and memory depth.
- Adds independent programmable read/write wait states and SEQ burst acceptance.
- Adds a two-cycle ERROR response for out-of-range addresses.
- Sits behind the AHB master as the single slave on a bus segment; word-addressed (haddr indexes words directly).

---
 rtl/ahb_pkg.sv | 26 ++
 rtl/ahb_slave_mem.sv | 37 +++
 rtl/ahb_slave_ws.sv | 134 +++++++++++++
 tb/tb_ahb_slave_ws.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the slave state type for the wait-state memory slave.
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      NONSEQ = 2'd2,
      SEQ    = 2'd3
   } htrans_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      IDLE_ST = 2'd0,
      WAIT_ST = 2'd1,
      ERR1    = 2'd2,
      ERR2    = 2'd3
   } slave_state_t;

   // Bit width able to index v distinct values, never less than one bit.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// Word memory with one write port and a registered read port; a same-edge write
// to the address being read is forwarded so the read never returns stale data.
module ahb_slave_mem
   import ahb_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = 256,
   localparam int AW       = clog2_min1(MEM_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
      end
   end

endmodule

// File: rtl/ahb_slave_ws.sv
// AHB-Lite word-addressed memory slave with programmable read/write wait states
// and a two-cycle ERROR response for addresses beyond the memory.
module ahb_slave_ws
   import ahb_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 8,
   parameter int MEM_DEPTH = 256,
   parameter int WR_WAIT   = 0,
   parameter int RD_WAIT   = 0
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic              hsel,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [DATA_W-1:0] hwdata,
   output logic              hready,
   output logic              hresp,
   output logic [DATA_W-1:0] hrdata
);

   localparam int MAX_WAIT = (WR_WAIT > RD_WAIT) ? WR_WAIT : RD_WAIT;
   localparam int CNT_W    = clog2_min1(MAX_WAIT + 1);
   localparam int MEM_AW   = clog2_min1(MEM_DEPTH);
   localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);
   localparam logic [CNT_W-1:0] WR_N    = CNT_W'(WR_WAIT);
   localparam logic [CNT_W-1:0] RD_N    = CNT_W'(RD_WAIT);

   slave_state_t      state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [MEM_AW-1:0] addr_q, addr_nx;
   logic              write_q, write_nx;
   logic              pend_q, pend_nx;
   logic              wr_en, rd_en;
   logic [MEM_AW-1:0] rd_addr;
   logic [CNT_W-1:0]  n_sel;
   logic              legal;
   logic              accept;
   htrans_t           trans;

   // Handshake: an address phase is taken only on an edge where hready=1, hsel=1 and
   // htrans is NONSEQ/SEQ; while hready=0 the master holds its address phase unsampled.
   assign trans  = htrans_t'(htrans);
   assign accept = hsel && ((trans == NONSEQ) || (trans == SEQ));
   assign legal  = ({1'b0, haddr} < DEPTH_L);
   assign n_sel  = hwrite ? WR_N : RD_N;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      addr_nx  = addr_q;
      write_nx = write_q;
      pend_nx  = pend_q;
      hready   = 1'b1;
      hresp    = HRESP_OKAY;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      rd_addr  = addr_q;
      case (state)
         WAIT_ST: begin
            hready = 1'b0;
            cnt_nx = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state_nx = IDLE_ST;
               rd_en    = !write_q;
            end
         end
         ERR1: begin
            hready   = 1'b0;
            hresp    = HRESP_ERROR;
            state_nx = ERR2;
         end
         ERR2: begin
            hresp = HRESP_ERROR;
         end
         default: ;
      endcase
      // IDLE_ST and ERR2 both present hready=1: finish any data phase, take the next one.
      if ((state == IDLE_ST) || (state == ERR2)) begin
         wr_en    = pend_q && write_q && !hreset;
         pend_nx  = 1'b0;
         state_nx = IDLE_ST;
         if (accept) begin
            addr_nx  = haddr[MEM_AW-1:0];
            write_nx = hwrite;
            if (!legal) begin
               state_nx = ERR1;
            end else begin
               pend_nx = 1'b1;
               if (n_sel == '0) begin
                  rd_en   = !hwrite;
                  rd_addr = haddr[MEM_AW-1:0];
               end else begin
                  state_nx = WAIT_ST;
                  cnt_nx   = n_sel;
               end
            end
         end
      end
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state   <= IDLE_ST;
         cnt     <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         addr_q  <= addr_nx;
         write_q <= write_nx;
         pend_q  <= pend_nx;
      end
   end

   ahb_slave_mem #(
      .DATA_W    (DATA_W),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_mem (
      .clk     (hclk),
      .rst     (hreset),
      .wr_en   (wr_en),
      .wr_addr (addr_q),
      .wr_data (hwdata),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (hrdata)
   );

endmodule

// File: tb/tb_ahb_slave_ws.sv
// Bench for ahb_slave_ws: two instances (zero-wait/16 words and 3/2-wait/256 words)
// checked against a transfer-level model, a vector table and directed sequences.
module tb_ahb_slave_ws;

   typedef struct {
      logic rdy;
      logic rsp;
      logic fin_rd;
      logic fin_wr;
      int   addr;
   } exp_t;

   typedef struct {
      logic        s;
      logic [1:0]  t;
      logic        w;
      logic [7:0]  a;
      logic [31:0] wd;
      logic        er;
      logic        ep;
      logic [31:0] ed;
   } vec_t;

   logic        hclk = 1'b0;
   logic        rst   [2];
   logic        sel   [2];
   logic [1:0]  trans [2];
   logic        wr    [2];
   logic [7:0]  addr  [2];
   logic [31:0] wdata [2];
   logic        rdy   [2];
   logic        rsp   [2];
   logic [31:0] rdata [2];

   int          n_chk  = 0;
   int          n_fail = 0;
   int          cyc    = 0;
   exp_t        exp_q   [2][$];
   exp_t        exp_cur [2];
   logic [31:0] last_rd [2];
   logic [31:0] mmem    [2][256];
   vec_t        tbl [10];

   always #5 hclk = ~hclk;

   ahb_slave_ws #(.DATA_W(32), .ADDR_W(8), .MEM_DEPTH(16), .WR_WAIT(0), .RD_WAIT(0)) u_a (
      .hclk(hclk), .hreset(rst[0]), .hsel(sel[0]), .htrans(trans[0]), .hwrite(wr[0]),
      .haddr(addr[0]), .hwdata(wdata[0]), .hready(rdy[0]), .hresp(rsp[0]), .hrdata(rdata[0])
   );

   ahb_slave_ws #(.DATA_W(32), .ADDR_W(8), .MEM_DEPTH(256), .WR_WAIT(3), .RD_WAIT(2)) u_b (
      .hclk(hclk), .hreset(rst[1]), .hsel(sel[1]), .htrans(trans[1]), .hwrite(wr[1]),
      .haddr(addr[1]), .hwdata(wdata[1]), .hready(rdy[1]), .hresp(rsp[1]), .hrdata(rdata[1])
   );

   function automatic exp_t mk(input logic r, input logic p, input logic fr, input logic fw, input int a);
      exp_t e;
      e.rdy = r; e.rsp = p; e.fin_rd = fr; e.fin_wr = fw; e.addr = a;
      return e;
   endfunction

   function automatic int depth_of(input int d);
      return (d == 0) ? 16 : 256;
   endfunction

   function automatic int waits_of(input int d, input logic w);
      if (d == 0) return 0;
      return w ? 3 : 2;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transfer-level model: each accepted transfer expands into its list of data-phase cycles.
   task automatic model_edge(input int d);
      exp_t c;
      int   n;
      c = exp_cur[d];
      if (rst[d]) begin
         exp_q[d].delete();
         exp_cur[d] = mk(1'b1, 1'b0, 1'b0, 1'b0, 0);
         last_rd[d] = '0;
         return;
      end
      if (c.fin_wr) mmem[d][c.addr] = wdata[d];
      if (c.fin_rd) last_rd[d] = mmem[d][c.addr];
      if (c.rdy && sel[d] && trans[d][1]) begin
         if (int'(addr[d]) >= depth_of(d)) begin
            exp_q[d].push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0));
            exp_q[d].push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 0));
         end else begin
            n = waits_of(d, wr[d]);
            for (int i = 0; i < n; i++) exp_q[d].push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
            exp_q[d].push_back(mk(1'b1, 1'b0, !wr[d], wr[d], int'(addr[d])));
         end
      end
      exp_cur[d] = (exp_q[d].size() > 0) ? exp_q[d].pop_front() : mk(1'b1, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic cycle(input int d);
      exp_t        c;
      logic [31:0] ed;
      @(posedge hclk);
      model_edge(d);
      cyc++;
      #1;
      c  = exp_cur[d];
      ed = c.fin_rd ? mmem[d][c.addr] : last_rd[d];
      chk($sformatf("model_hready%0d", d), 32'(rdy[d]), 32'(c.rdy));
      chk($sformatf("model_hresp%0d", d), 32'(rsp[d]), 32'(c.rsp));
      chk($sformatf("model_hrdata%0d", d), rdata[d], ed);
   endtask

   // Master: hold the address phase until hready, take it, then drive write data.
   task automatic issue(input int d, input logic [1:0] t, input logic w, input logic [7:0] a,
                        input logic [31:0] wd, output int stalls);
      sel[d] = 1'b1; trans[d] = t; wr[d] = w; addr[d] = a;
      stalls = 0;
      while (!rdy[d] && stalls < 40) begin
         cycle(d);
         stalls++;
      end
      chk("issue_hready_timeout", 32'(rdy[d]), 32'd1);
      cycle(d);
      if (t[1] && w) wdata[d] = wd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int          st;
      int          c0;
      int          bad;
      logic        acc;
      logic [31:0] v;

      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; sel[d] = 1'b0; trans[d] = 2'd0; wr[d] = 1'b0;
         addr[d] = 8'h0; wdata[d] = 32'h0; last_rd[d] = 32'h0;
         exp_cur[d] = mk(1'b1, 1'b0, 1'b0, 1'b0, 0);
      end
      for (int i = 0; i < 16; i++) begin
         v = $urandom;
         u_a.u_mem.mem[i[3:0]] = v;
         mmem[0][i] = v;
      end
      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         u_b.u_mem.mem[i[7:0]] = v;
         mmem[1][i] = v;
      end

      repeat (2) @(posedge hclk);
      #1;
      rst[0] = 1'b0; rst[1] = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset_hready%0d", d), 32'(rdy[d]), 32'd1);
         chk($sformatf("reset_hresp%0d", d), 32'(rsp[d]), 32'd0);
         chk($sformatf("reset_hrdata%0d", d), rdata[d], 32'd0);
      end

      // Zero-wait instance: write, write+bypass read, error then write, BUSY, read back.
      tbl[0] = '{1'b1, 2'd2, 1'b1, 8'h0d, 32'h0,        1'b1, 1'b0, 32'h0};
      tbl[1] = '{1'b1, 2'd2, 1'b1, 8'h08, 32'h5a5a5a5a, 1'b1, 1'b0, 32'h0};
      tbl[2] = '{1'b1, 2'd2, 1'b0, 8'h08, 32'h55,       1'b1, 1'b0, 32'h55};
      tbl[3] = '{1'b1, 2'd2, 1'b0, 8'h20, 32'h0,        1'b0, 1'b1, 32'h55};
      tbl[4] = '{1'b1, 2'd2, 1'b0, 8'h20, 32'h0,        1'b1, 1'b1, 32'h55};
      tbl[5] = '{1'b1, 2'd2, 1'b1, 8'h03, 32'h0,        1'b1, 1'b0, 32'h55};
      tbl[6] = '{1'b0, 2'd0, 1'b0, 8'h00, 32'h33,       1'b1, 1'b0, 32'h55};
      tbl[7] = '{1'b1, 2'd1, 1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 32'h55};
      tbl[8] = '{1'b1, 2'd2, 1'b0, 8'h0d, 32'h0,        1'b1, 1'b0, 32'h5a5a5a5a};
      tbl[9] = '{1'b0, 2'd0, 1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 32'h5a5a5a5a};
      for (int i = 0; i < 10; i++) begin
         sel[0] = tbl[i].s; trans[0] = tbl[i].t; wr[0] = tbl[i].w;
         addr[0] = tbl[i].a; wdata[0] = tbl[i].wd;
         cycle(0);
         chk($sformatf("tbl_hready[%0d]", i), 32'(rdy[0]), 32'(tbl[i].er));
         chk($sformatf("tbl_hresp[%0d]", i), 32'(rsp[0]), 32'(tbl[i].ep));
         chk($sformatf("tbl_hrdata[%0d]", i), rdata[0], tbl[i].ed);
      end
      chk("mem_a_0d", u_a.u_mem.mem[4'hd], 32'h5a5a5a5a);
      chk("mem_a_08", u_a.u_mem.mem[4'h8], 32'h55);
      chk("mem_a_03", u_a.u_mem.mem[4'h3], 32'h33);

      // Two-wait read.
      u_b.u_mem.mem[8'h1d] = 32'ha5a5a5a5;
      mmem[1][8'h1d] = 32'ha5a5a5a5;
      issue(1, 2'd2, 1'b0, 8'h1d, 32'h0, st);
      issue(1, 2'd0, 1'b0, 8'h00, 32'h0, st);
      chk("rd_wait_stalls", 32'(st), 32'd2);
      chk("rd_wait_hrdata", rdata[1], 32'ha5a5a5a5);

      // Three-wait write burst with a BUSY after beat 2.
      issue(1, 2'd2, 1'b1, 8'h04, 32'h40, st);
      c0 = cyc;
      issue(1, 2'd3, 1'b1, 8'h05, 32'h41, st);
      issue(1, 2'd1, 1'b1, 8'h06, 32'h0, st);
      chk("busy_hready", 32'(rdy[1]), 32'd1);
      chk("busy_hresp", 32'(rsp[1]), 32'd0);
      issue(1, 2'd3, 1'b1, 8'h06, 32'h42, st);
      issue(1, 2'd3, 1'b1, 8'h07, 32'h43, st);
      issue(1, 2'd0, 1'b0, 8'h00, 32'h0, st);
      chk("burst_cycles", 32'(cyc - c0), 32'd17);
      for (int i = 0; i < 4; i++) begin
         v = 32'h40 + 32'(i);
         chk($sformatf("burst_mem[%0d]", 4 + i), u_b.u_mem.mem[8'(4 + i)], v);
      end

      // Reset in the middle of a write wait state drops the write.
      u_b.u_mem.mem[8'h09] = 32'h11;
      mmem[1][8'h09] = 32'h11;
      issue(1, 2'd2, 1'b1, 8'h09, 32'h99, st);
      sel[1] = 1'b0; trans[1] = 2'd0;
      cycle(1);
      rst[1] = 1'b1;
      cycle(1);
      rst[1] = 1'b0;
      chk("midrst_hready", 32'(rdy[1]), 32'd1);
      chk("midrst_hresp", 32'(rsp[1]), 32'd0);
      chk("midrst_hrdata", rdata[1], 32'd0);
      repeat (5) cycle(1);
      chk("midrst_mem09", u_b.u_mem.mem[8'h09], 32'h11);

      // Randomised traffic on both instances.
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 300; k++) begin
            if (rdy[d]) begin
               sel[d]   = ($urandom_range(0, 4) != 0);
               trans[d] = 2'($urandom_range(0, 3));
               wr[d]    = 1'($urandom_range(0, 1));
               addr[d]  = (d == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
            end
            acc = rdy[d] && sel[d] && trans[d][1] && wr[d];
            cycle(d);
            if (acc) wdata[d] = $urandom;
         end
         sel[d] = 1'b0; trans[d] = 2'd0;
         repeat (10) cycle(d);
      end

      bad = 0;
      for (int i = 0; i < 16; i++) if (u_a.u_mem.mem[i[3:0]] !== mmem[0][i]) bad++;
      chk("mem_a_all_words", 32'(bad), 32'd0);
      bad = 0;
      for (int i = 0; i < 256; i++) if (u_b.u_mem.mem[i[7:0]] !== mmem[1][i]) bad++;
      chk("mem_b_all_words", 32'(bad), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
